// File: rtl/vga_bounce_box.sv
// Moving-square test pattern for vga_ctrl: a box that steps once per frame and bounces off the active-area edges.
// Optional macro VGA_BOX_COLOR_CYCLE_EN cycles the box colour through a 6-entry palette on every bounce.
module vga_bounce_box #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          INIT_X    = 0,
    parameter int          INIT_Y    = 0,
    parameter logic [11:0] BOX_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h00F,
    parameter int          VS_POL    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vs,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [11:0] pixel,
    output logic        bounce
);

    localparam logic [10:0] H_A    = 11'(H_ACTIVE);
    localparam logic [10:0] V_A    = 11'(V_ACTIVE);
    localparam logic [10:0] BOX    = 11'(BOX_SIZE);
    localparam logic [10:0] STP    = 11'(STEP);
    localparam logic [9:0]  X0     = 10'(INIT_X);
    localparam logic [9:0]  Y0     = 10'(INIT_Y);
    localparam logic        VS_ACT = (VS_POL != 0);

    localparam bit PARAMS_OK = (BOX_SIZE <= V_ACTIVE) && (STEP >= 1) &&
                               (STEP <= V_ACTIVE - BOX_SIZE) &&
                               (INIT_X + BOX_SIZE <= H_ACTIVE) &&
                               (INIT_Y + BOX_SIZE <= V_ACTIVE);

    logic [9:0]  box_x, box_y;
    logic        dx, dy;
    logic        vs_q;
    logic        move;
    logic [11:0] x_next, y_next;
    logic        active, inbox;
    logic [11:0] box_color;
    logic [10:0] px, py, bx, by;

    // Returns {bounced, new_dir, new_pos}; all arithmetic in 11 bits so nothing wraps.
    function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir,
                                              input logic [10:0] limit);
        logic [10:0] p;
        p = {1'b0, pos};
        if (!dir) begin
            if (p + STP + BOX > limit) return {1'b1, 1'b1, 10'(limit - BOX)};
            return {1'b0, 1'b0, 10'(p + STP)};
        end
        if (p < STP) return {1'b1, 1'b0, 10'd0};
        return {1'b0, 1'b1, 10'(p - STP)};
    endfunction

    always_comb begin
        move   = (vs == VS_ACT) && (vs_q != VS_ACT) && en;
        x_next = step_axis(box_x, dx, H_A);
        y_next = step_axis(box_y, dy, V_A);
        px     = {1'b0, pix_x};
        py     = {1'b0, pix_y};
        bx     = {1'b0, box_x};
        by     = {1'b0, box_y};
        active = (px < H_A) && (py < V_A);
        inbox  = (px >= bx) && (px < bx + BOX) && (py >= by) && (py < by + BOX);
    end

`ifdef VGA_BOX_COLOR_CYCLE_EN
    logic [2:0] color_idx;

    always_ff @(posedge clk) begin
        if (rst)
            color_idx <= '0;
        else if (bounce)
            color_idx <= (color_idx == 3'd5) ? 3'd0 : color_idx + 3'd1;
    end

    always_comb begin
        box_color = 12'hF00;
        case (color_idx)
            3'd0:    box_color = 12'hF00;
            3'd1:    box_color = 12'hFF0;
            3'd2:    box_color = 12'h0F0;
            3'd3:    box_color = 12'h0FF;
            3'd4:    box_color = 12'h00F;
            3'd5:    box_color = 12'hF0F;
            default: box_color = 12'hF00;
        endcase
    end
`else
    always_comb box_color = BOX_COLOR;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            box_x  <= X0;
            box_y  <= Y0;
            dx     <= 1'b0;
            dy     <= 1'b0;
            vs_q   <= ~VS_ACT;
            bounce <= 1'b0;
            pixel  <= '0;
        end else begin
            vs_q   <= vs;
            bounce <= 1'b0;
            if (move) begin
                box_x  <= x_next[9:0];
                dx     <= x_next[10];
                box_y  <= y_next[9:0];
                dy     <= y_next[10];
                bounce <= x_next[11] | y_next[11];
            end
            pixel <= active ? (inbox ? box_color : BG_COLOR) : '0;
        end
    end

    always_ff @(posedge clk) begin
        assert (PARAMS_OK) else $error("vga_bounce_box: illegal parameter combination");
    end

endmodule

// File: tb/tb_vga_bounce_box.sv
// Randomized bench for vga_bounce_box against a clamp-and-reflect position model.
module tb_vga_bounce_box;

    localparam int H = 640;
    localparam int V = 480;
    localparam int BOX = 32;
    localparam int STEP = 2;
    localparam logic [11:0] BG = 12'h00F;
`ifdef VGA_BOX_COLOR_CYCLE_EN
    localparam logic [11:0] BOXC0 = 12'hF00;
`else
    localparam logic [11:0] BOXC0 = 12'hFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        vs  = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic [11:0] pixel;
    logic        bounce;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: position, direction (+1/-1), colour index, pending bounce pulse.
    int m_x, m_y, m_vx, m_vy, m_cidx;
    bit m_prev_vs, m_bounce;
    int ticks;
    logic [11:0] palette [6] = '{12'hF00, 12'hFF0, 12'h0F0, 12'h0FF, 12'h00F, 12'hF0F};

    vga_bounce_box #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(BOX), .STEP(STEP),
        .INIT_X(0), .INIT_Y(0), .BOX_COLOR(12'hFFF), .BG_COLOR(BG), .VS_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .vs(vs),
        .pix_x(pix_x), .pix_y(pix_y), .pixel(pixel), .bounce(bounce)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] box_col();
`ifdef VGA_BOX_COLOR_CYCLE_EN
        return palette[m_cidx];
`else
        return 12'hFFF;
`endif
    endfunction

    function automatic logic [11:0] exp_pixel(input int x, input int y);
        if (x >= H || y >= V) return 12'h000;
        if (x >= m_x && x < m_x + BOX && y >= m_y && y < m_y + BOX) return box_col();
        return BG;
    endfunction

    // Move by one step; if that would leave [0, lim-BOX], clamp to the wall and reverse.
    task automatic move_axis(inout int pos, inout int vel, input int lim, output bit hit);
        int cand;
        cand = pos + vel * STEP;
        hit = 1'b0;
        if (cand < 0) begin
            pos = 0; vel = 1; hit = 1'b1;
        end else if (cand + BOX > lim) begin
            pos = lim - BOX; vel = -1; hit = 1'b1;
        end else begin
            pos = cand;
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_vx = 1; m_vy = 1;
        m_cidx = 0; m_prev_vs = 1'b1; m_bounce = 1'b0;
    endtask

    // One clock: predict from current inputs/state, advance model, then compare after the edge.
    task automatic cycle();
        logic [11:0] ep;
        bit eb, hx, hy;
        eb = 1'b0;
        if (rst) begin
            ep = 12'h000;
            model_reset();
        end else begin
            ep = exp_pixel(int'(pix_x), int'(pix_y));
            if (m_bounce) m_cidx = (m_cidx + 1) % 6;
            if (vs == 1'b0 && m_prev_vs == 1'b1 && en) begin
                move_axis(m_x, m_vx, H, hx);
                move_axis(m_y, m_vy, V, hy);
                eb = hx | hy;
                ticks++;
            end
            m_prev_vs = vs;
        end
        m_bounce = eb;
        @(posedge clk);
        #1;
        check("pixel", pixel, ep);
        check("bounce", {11'd0, bounce}, {11'd0, eb});
    endtask

    task automatic rand_pix();
        int x, y;
        case ($urandom_range(0, 4))
            0: x = m_x - 1;
            1: x = m_x;
            2: x = m_x + BOX - 1;
            3: x = m_x + BOX;
            default: x = $urandom_range(0, 700);
        endcase
        case ($urandom_range(0, 4))
            0: y = m_y - 1;
            1: y = m_y;
            2: y = m_y + BOX - 1;
            3: y = m_y + BOX;
            default: y = $urandom_range(0, 540);
        endcase
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        pix_x = 10'(x);
        pix_y = 10'(y);
    endtask

    task automatic frame(input int low_len, input int high_len);
        vs = 1'b0;
        for (int i = 0; i < low_len; i++) begin rand_pix(); cycle(); end
        vs = 1'b1;
        for (int i = 0; i < high_len; i++) begin rand_pix(); cycle(); end
    endtask

    task automatic probe(input int x, input int y, input logic [11:0] plan);
        pix_x = 10'(x);
        pix_y = 10'(y);
        cycle();
        check("plan_pixel", pixel, plan);
    endtask

    initial begin
        ticks = 0;
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;

        // Reset position, no ticks
        probe(0, 0, BOXC0);
        probe(31, 31, BOXC0);
        probe(32, 0, BG);
        probe(640, 0, 12'h000);
        probe(0, 480, 12'h000);

        // Ten frames: box reaches (20,20)
        en = 1'b1;
        for (int f = 0; f < 10; f++) frame(2, 3);
        probe(19, 20, BG);
        probe(20, 20, BOXC0);
        probe(51, 51, BOXC0);
        probe(52, 51, BG);

        // Run through the y bounce (tick 225) and x bounce (tick 305)
        while (ticks < 330) frame($urandom_range(1, 5), $urandom_range(1, 4));

        // Frozen while disabled, then resume
        en = 1'b0;
        for (int f = 0; f < 5; f++) frame($urandom_range(1, 4), $urandom_range(1, 4));
        en = 1'b1;
        for (int f = 0; f < 5; f++) frame($urandom_range(1, 4), $urandom_range(1, 4));

        // Long sync pulse: a single update
        vs = 1'b0;
        for (int i = 0; i < 1000; i++) begin rand_pix(); cycle(); end
        vs = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_pix(); cycle(); end

        // Mid-frame reset
        for (int f = 0; f < 7; f++) frame(2, 3);
        vs = 1'b0;
        rand_pix(); cycle();
        rst = 1'b1;
        rand_pix(); cycle();
        check("rst_pixel", pixel, 12'h000);
        rst = 1'b0;
        vs = 1'b1;
        probe(0, 0, BOXC0);
        probe(32, 32, BG);

        // Random enable and pulse shapes
        for (int f = 0; f < 500; f++) begin
            en = ($urandom_range(0, 9) < 8);
            frame($urandom_range(1, 6), $urandom_range(1, 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_bounce_box.md
Name: vga_bounce_box

Overview:
- Pixel source that sits directly upstream of vga_ctrl.
- Consumes the scan coordinates pix_x/pix_y and the vertical sync from vga_ctrl.
- Returns a registered 12-bit RGB pixel: a solid square that moves by a fixed step once per frame and bounces off the active-area edges, drawn over a flat background.
- Replaces the static colour-bar generator as the display test pattern.

Parameters:
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in lines
- BOX_SIZE, 32, square edge length in pixels
- STEP, 2, pixels moved per frame on each axis
- INIT_X, 0, box left edge after reset
- INIT_Y, 0, box top edge after reset
- BOX_COLOR, 12'hFFF, box colour (RGB444)
- BG_COLOR, 12'h00F, background colour inside the active area
- VS_POL, 0, sync polarity of vs (0 = active-low pulse)

Ports:
- clk  input  1  pixel clock (same clock as vga_ctrl)
- rst  input  1  synchronous active-high reset
- en  input  1  1 = motion enabled; 0 = position frozen
- vs  input  1  vertical sync from vga_ctrl
- pix_x  input  10  current column from vga_ctrl
- pix_y  input  10  current line from vga_ctrl
- pixel  output  12  RGB444 pixel to vga_ctrl, registered
- bounce  output  1  one-cycle pulse when either axis reverses direction

Behaviour:
- Reset and clock: single clock domain; rst is sampled on the rising edge of clk (synchronous, active-high).
- Reset values:
  - pixel = 0, bounce = 0
  - box_x = INIT_X, box_y = INIT_Y
  - dx = dy = 0 (0 = increasing, 1 = decreasing)
  - vs_q = inactive level (!VS_POL)
  - colour index = 0
- Reset mid-frame takes effect on the next edge; no partial update survives.
- Frame tick:
  - vs is registered into vs_q.
  - tick = (vs == VS_POL) && (vs_q != VS_POL), i.e. the first cycle of the sync pulse.
  - Exactly one tick per sync pulse, regardless of pulse length.
  - A tick is ignored when en = 0; tick and en are evaluated in the same cycle.
- Motion on tick, x axis (11-bit internal arithmetic, no wrap):
  - dx = 0 and box_x + STEP + BOX_SIZE > H_ACTIVE: box_x <= H_ACTIVE - BOX_SIZE, dx <= 1, axis bounced.
  - dx = 0 otherwise: box_x <= box_x + STEP.
  - dx = 1 and box_x < STEP: box_x <= 0, dx <= 0, axis bounced.
  - dx = 1 otherwise: box_x <= box_x - STEP.
- Motion on tick, y axis: identical rule using V_ACTIVE, box_y and dy.
- bounce output:
  - Asserted for exactly the one cycle after a tick in which at least one axis bounced.
  - Both axes bouncing on the same tick gives a single pulse.
- Pixel path, latency exactly 1 clk from pix_x/pix_y to pixel:
  - active = pix_x < H_ACTIVE && pix_y < V_ACTIVE
  - inbox = box_x <= pix_x < box_x + BOX_SIZE && box_y <= pix_y < box_y + BOX_SIZE
  - pixel <= active ? (inbox ? box colour : BG_COLOR) : 12'h000
- Position registers change only on a tick, which falls in vertical blanking, so no tearing occurs within the visible frame.
- Parameter legality, checked by simulation assertion:
  - BOX_SIZE ≤ V_ACTIVE
  - 1 ≤ STEP ≤ V_ACTIVE - BOX_SIZE
  - INIT_X + BOX_SIZE ≤ H_ACTIVE
  - INIT_Y + BOX_SIZE ≤ V_ACTIVE

Optional Feature:
- Macro: VGA_BOX_COLOR_CYCLE_EN.
- Defined:
  - Box colour comes from a 6-entry palette: F00, FF0, 0F0, 0FF, 00F, F0F.
  - Palette index resets to 0 and advances by 1 (wrapping 5 → 0) on each bounce pulse.
  - Simultaneous bounce on both axes advances the index by 1 only.
  - BOX_COLOR is unused.
- Undefined: box colour is constant BOX_COLOR; no palette logic is synthesised.

Test Plan:
1. Reset, no ticks. Present (0,0), then (31,31), (32,0), (640,0), (0,480) -> pixel one cycle later = FFF, FFF, 00F, 000, 000. bounce = 0 throughout.
2. en = 1, 10 vs pulses (low for 2 lines each) -> box at (20,20). Pixel values:
   - (19,20) = 00F
   - (20,20) = FFF
   - (51,51) = FFF
   - (52,51) = 00F
3. Y edge, en = 1:
   - After 224 ticks: box_y = 448.
   - Tick 225: box_y stays 448, dy = 1, bounce high for exactly 1 cycle.
   - Tick 226: box_y = 446.
   - X edge: box_x = 608 at tick 304; bounce at tick 305.
4. en = 0 across 5 vs pulses -> box position unchanged, no bounce. en = 1 then resumes from the same position.
5. vs held at active level for 1000 cycles -> exactly one position update. Assert rst mid-frame -> next cycle the box is at (INIT_X,INIT_Y) and pixel = 0.
6. VGA_BOX_COLOR_CYCLE_EN defined:
   - Box colour is F00 after reset.
   - After the y bounce at tick 225: FF0.
   - INIT_X = INIT_Y = 0 with H_ACTIVE = V_ACTIVE = 480 gives a corner hit: single pulse, colour advances one step.
